// File: rtl/id_ex_register_if.sv
// ID/EX boundary bundle.
//   master : decode side (drives ID fields, flush/ex_busy/write-back info,
//            observes EX fields and the stall outputs)
//   slave  : the id_ex_register itself
// Signals:
//   valid_id, ra_id, rb_id, rw_id, busa_id, busb_id, imm_id, pc_id, ctrl_id  - ID payload
//   flush, ex_busy                                                          - hazard controls
//   wb_reg_write, wb_rw, wb_busw                                            - write-back port
//   valid_ex, ra_ex, rb_ex, rw_ex, busa_ex, busb_ex, imm_ex, pc_ex, ctrl_ex  - EX payload
//   stall_id (combinational), stall_cnt (registered, saturating)
interface id_ex_register_if #(
  parameter int unsigned CTRL_W = 12
);
  localparam int unsigned REG_W  = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 16;

  logic                valid_id;
  logic [REG_W-1:0]    ra_id;
  logic [REG_W-1:0]    rb_id;
  logic [REG_W-1:0]    rw_id;
  logic [DATA_W-1:0]   busa_id;
  logic [DATA_W-1:0]   busb_id;
  logic [DATA_W-1:0]   imm_id;
  logic [DATA_W-1:0]   pc_id;
  logic [CTRL_W-1:0]   ctrl_id;

  logic                flush;
  logic                ex_busy;
  logic                wb_reg_write;
  logic [REG_W-1:0]    wb_rw;
  logic [DATA_W-1:0]   wb_busw;

  logic                valid_ex;
  logic [REG_W-1:0]    ra_ex;
  logic [REG_W-1:0]    rb_ex;
  logic [REG_W-1:0]    rw_ex;
  logic [DATA_W-1:0]   busa_ex;
  logic [DATA_W-1:0]   busb_ex;
  logic [DATA_W-1:0]   imm_ex;
  logic [DATA_W-1:0]   pc_ex;
  logic [CTRL_W-1:0]   ctrl_ex;

  logic                stall_id;
  logic [CNT_W-1:0]    stall_cnt;

  modport master (
    output valid_id, ra_id, rb_id, rw_id, busa_id, busb_id, imm_id, pc_id, ctrl_id,
    output flush, ex_busy, wb_reg_write, wb_rw, wb_busw,
    input  valid_ex, ra_ex, rb_ex, rw_ex, busa_ex, busb_ex, imm_ex, pc_ex, ctrl_ex,
    input  stall_id, stall_cnt
  );

  modport slave (
    input  valid_id, ra_id, rb_id, rw_id, busa_id, busb_id, imm_id, pc_id, ctrl_id,
    input  flush, ex_busy, wb_reg_write, wb_rw, wb_busw,
    output valid_ex, ra_ex, rb_ex, rw_ex, busa_ex, busb_ex, imm_ex, pc_ex, ctrl_ex,
    output stall_id, stall_cnt
  );
endinterface

// File: rtl/id_ex_register.sv
// ID/EX pipeline register with load-use bubble insertion, multicycle-EX
// hold, branch flush and optional same-cycle write-back bypass.
// Ports:
//   clk   - pipeline clock, all state updates on the rising edge
//   reset - synchronous, active-high
//   bus   - id_ex_register_if.slave (ID payload in, EX payload out,
//           flush/ex_busy/write-back in, stall_id/stall_cnt out)
// Build option: define FORWARD_WB_EN to bypass wb_busw into busa_ex/busb_ex
// when the write-back destination matches a source index on a loading edge.
module id_ex_register #(
  parameter int unsigned CTRL_W = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  id_ex_register_if.slave      bus
);
  localparam int unsigned REG_W       = 5;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned CNT_W       = 16;
  localparam int unsigned CTRL_MEM_RD = 1;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HOLD   = 2'd1,
    ST_BUBBLE = 2'd2
  } state_t;

  typedef struct packed {
    logic              valid;
    logic [REG_W-1:0]  ra;
    logic [REG_W-1:0]  rb;
    logic [REG_W-1:0]  rw;
    logic [DATA_W-1:0] busa;
    logic [DATA_W-1:0] busb;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc;
    logic [CTRL_W-1:0] ctrl;
  } ex_t;

  state_t            state_q, state_d;
  ex_t               ex_q, ex_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              load_use;
  logic              stall;
  logic [DATA_W-1:0] busa_sel;
  logic [DATA_W-1:0] busb_sel;

  // Load in EX whose destination feeds a source of the ID instruction.
  assign load_use = bus.valid_id & ex_q.valid & ex_q.ctrl[CTRL_MEM_RD] &
                    (ex_q.rw != '0) &
                    ((ex_q.rw == bus.ra_id) | (ex_q.rw == bus.rb_id));

  assign stall = (bus.ex_busy | load_use) & ~bus.flush & ~reset;

`ifdef FORWARD_WB_EN
  // Register bank writes on the same edge ID samples it; take the new value.
  logic fwd_a, fwd_b;
  assign fwd_a    = bus.wb_reg_write & (bus.wb_rw != '0) & (bus.wb_rw == bus.ra_id);
  assign fwd_b    = bus.wb_reg_write & (bus.wb_rw != '0) & (bus.wb_rw == bus.rb_id);
  assign busa_sel = fwd_a ? bus.wb_busw : bus.busa_id;
  assign busb_sel = fwd_b ? bus.wb_busw : bus.busb_id;
`else
  logic unused_wb;
  assign unused_wb = ^{bus.wb_reg_write, bus.wb_rw, bus.wb_busw};
  assign busa_sel  = bus.busa_id;
  assign busb_sel  = bus.busb_id;
`endif

  // State and payload registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      ex_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ex_q    <= ex_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state / next payload, in flush > ex_busy > load_use > load order.
  always_comb begin
    state_d = state_q;
    ex_d    = ex_q;
    cnt_d   = cnt_q;

    if (bus.flush) begin
      state_d = ST_RUN;
      ex_d    = '0;
    end else if (bus.ex_busy) begin
      state_d = ST_HOLD;
    end else if (load_use) begin
      state_d = ST_BUBBLE;
      ex_d    = '0;
    end else begin
      state_d    = ST_RUN;
      ex_d.valid = bus.valid_id;
      ex_d.ra    = bus.ra_id;
      ex_d.rb    = bus.rb_id;
      ex_d.rw    = bus.rw_id;
      ex_d.busa  = busa_sel;
      ex_d.busb  = busb_sel;
      ex_d.imm   = bus.imm_id;
      ex_d.pc    = bus.pc_id;
      ex_d.ctrl  = bus.valid_id ? bus.ctrl_id : '0;
    end

    if (stall && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign bus.valid_ex  = ex_q.valid;
  assign bus.ra_ex     = ex_q.ra;
  assign bus.rb_ex     = ex_q.rb;
  assign bus.rw_ex     = ex_q.rw;
  assign bus.busa_ex   = ex_q.busa;
  assign bus.busb_ex   = ex_q.busb;
  assign bus.imm_ex    = ex_q.imm;
  assign bus.pc_ex     = ex_q.pc;
  assign bus.ctrl_ex   = ex_q.ctrl;
  assign bus.stall_id  = stall;
  assign bus.stall_cnt = cnt_q;
endmodule

// File: tb/tb_id_ex_register.sv
module tb_id_ex_register;
  localparam int unsigned CTRL_W = 12;
`ifdef FORWARD_WB_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;

  id_ex_register_if #(.CTRL_W(CTRL_W)) bus ();

  id_ex_register #(.CTRL_W(CTRL_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Expected EX outputs after an edge plus stall_id during the cycle before it.
  typedef struct {
    logic        valid;
    logic [4:0]  ra, rb, rw;
    logic [31:0] busa, busb, imm, pc;
    logic [11:0] ctrl;
    logic        stall;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];
  exp_t prev, cur, hold_e;
  bit   have_prev = 1'b0;
  int   n_checks  = 0;
  int   n_fail    = 0;

  function automatic exp_t mk(logic v, logic [4:0] ra, logic [4:0] rb, logic [4:0] rw,
                              logic [31:0] a, logic [31:0] b, logic [31:0] imm,
                              logic [31:0] pc, logic [11:0] ctrl, logic st, logic [15:0] cnt);
    exp_t e;
    e.valid = v; e.ra = ra; e.rb = rb; e.rw = rw;
    e.busa = a; e.busb = b; e.imm = imm; e.pc = pc;
    e.ctrl = ctrl; e.stall = st; e.cnt = cnt;
    return e;
  endfunction

  function automatic exp_t zero(logic st, logic [15:0] cnt);
    return mk(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 12'd0, st, cnt);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [4:0] ra, input logic [4:0] rb,
                        input logic [4:0] rw, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] imm, input logic [31:0] pc, input logic [11:0] ctrl);
    bus.valid_id = v; bus.ra_id = ra; bus.rb_id = rb; bus.rw_id = rw;
    bus.busa_id = a; bus.busb_id = b; bus.imm_id = imm; bus.pc_id = pc;
    bus.ctrl_id = ctrl;
  endtask

  task automatic step(input exp_t e);
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: outputs of the previous item, stall_id of the current one.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (have_prev) begin
        chk("valid_ex",  32'(bus.valid_ex),  32'(prev.valid));
        chk("ra_ex",     32'(bus.ra_ex),     32'(prev.ra));
        chk("rb_ex",     32'(bus.rb_ex),     32'(prev.rb));
        chk("rw_ex",     32'(bus.rw_ex),     32'(prev.rw));
        chk("busa_ex",   bus.busa_ex,        prev.busa);
        chk("busb_ex",   bus.busb_ex,        prev.busb);
        chk("imm_ex",    bus.imm_ex,         prev.imm);
        chk("pc_ex",     bus.pc_ex,          prev.pc);
        chk("ctrl_ex",   32'(bus.ctrl_ex),   32'(prev.ctrl));
        chk("stall_cnt", 32'(bus.stall_cnt), 32'(prev.cnt));
      end
      if (q.size() > 0) begin
        cur = q.pop_front();
        chk("stall_id", 32'(bus.stall_id), 32'(cur.stall));
        prev      = cur;
        have_prev = 1'b1;
      end else begin
        have_prev = 1'b0;
      end
    end
  end

  initial begin : stimulus
    bus.flush = 1'b0; bus.ex_busy = 1'b0;
    bus.wb_reg_write = 1'b0; bus.wb_rw = 5'd0; bus.wb_busw = 32'd0;
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 12'd0);
    @(posedge clk);
    #1;

    // Reset
    reset = 1'b1;
    step(zero(1'b0, 16'd0));
    step(zero(1'b0, 16'd0));
    reset = 1'b0;

    // Basic capture, then a load in EX
    set_id(1'b1, 5'd3, 5'd4, 5'd6, 32'h11, 32'h22, 32'h100, 32'h1000, 12'h001);
    step(mk(1'b1, 5'd3, 5'd4, 5'd6, 32'h11, 32'h22, 32'h100, 32'h1000, 12'h001, 1'b0, 16'd0));
    set_id(1'b1, 5'd1, 5'd2, 5'd5, 32'hA, 32'hB, 32'h4, 32'h1004, 12'h003);
    step(mk(1'b1, 5'd1, 5'd2, 5'd5, 32'hA, 32'hB, 32'h4, 32'h1004, 12'h003, 1'b0, 16'd0));

    // Load-use on ra=5: one bubble, then capture
    set_id(1'b1, 5'd5, 5'd0, 5'd7, 32'h55, 32'h66, 32'h8, 32'h1008, 12'h001);
    step(zero(1'b1, 16'd1));
    step(mk(1'b1, 5'd5, 5'd0, 5'd7, 32'h55, 32'h66, 32'h8, 32'h1008, 12'h001, 1'b0, 16'd1));

    // Load targeting r0 never stalls
    set_id(1'b1, 5'd1, 5'd2, 5'd0, 32'h1, 32'h2, 32'hC, 32'h100C, 12'h003);
    step(mk(1'b1, 5'd1, 5'd2, 5'd0, 32'h1, 32'h2, 32'hC, 32'h100C, 12'h003, 1'b0, 16'd1));
    set_id(1'b1, 5'd0, 5'd0, 5'd8, 32'h80, 32'h81, 32'h10, 32'h1010, 12'h001);
    hold_e = mk(1'b1, 5'd0, 5'd0, 5'd8, 32'h80, 32'h81, 32'h10, 32'h1010, 12'h001, 1'b0, 16'd1);
    step(hold_e);

    // ex_busy for 3 cycles: outputs hold, then capture
    bus.ex_busy = 1'b1;
    set_id(1'b1, 5'd9, 5'd10, 5'd11, 32'h90, 32'hA0, 32'h14, 32'h1014, 12'h001);
    for (int i = 0; i < 3; i++) begin
      hold_e.stall = 1'b1;
      hold_e.cnt   = 16'(i + 2);
      step(hold_e);
    end
    bus.ex_busy = 1'b0;
    step(mk(1'b1, 5'd9, 5'd10, 5'd11, 32'h90, 32'hA0, 32'h14, 32'h1014, 12'h001, 1'b0, 16'd4));

    // Flush coincident with ex_busy and load_use
    set_id(1'b1, 5'd1, 5'd2, 5'd12, 32'hC1, 32'hC2, 32'h18, 32'h1018, 12'h003);
    step(mk(1'b1, 5'd1, 5'd2, 5'd12, 32'hC1, 32'hC2, 32'h18, 32'h1018, 12'h003, 1'b0, 16'd4));
    set_id(1'b1, 5'd12, 5'd3, 5'd13, 32'hD1, 32'hD2, 32'h1C, 32'h101C, 12'h0F0);
    bus.flush = 1'b1; bus.ex_busy = 1'b1;
    step(zero(1'b0, 16'd4));
    bus.flush = 1'b0; bus.ex_busy = 1'b0;
    step(mk(1'b1, 5'd12, 5'd3, 5'd13, 32'hD1, 32'hD2, 32'h1C, 32'h101C, 12'h0F0, 1'b0, 16'd4));

    // valid_id=0 loads with ctrl cleared
    set_id(1'b0, 5'd1, 5'd2, 5'd14, 32'hE1, 32'hE2, 32'h20, 32'h1020, 12'h003);
    step(mk(1'b0, 5'd1, 5'd2, 5'd14, 32'hE1, 32'hE2, 32'h20, 32'h1020, 12'h000, 1'b0, 16'd4));

    // Write-back bypass on A, none for r0, bypass on B
    bus.wb_reg_write = 1'b1; bus.wb_rw = 5'd7; bus.wb_busw = 32'hDEADBEEF;
    set_id(1'b1, 5'd7, 5'd2, 5'd15, 32'h7, 32'h22, 32'h24, 32'h1024, 12'h001);
    step(mk(1'b1, 5'd7, 5'd2, 5'd15, FWD ? 32'hDEADBEEF : 32'h7, 32'h22, 32'h24, 32'h1024,
            12'h001, 1'b0, 16'd4));
    bus.wb_rw = 5'd0;
    set_id(1'b1, 5'd0, 5'd0, 5'd16, 32'h33, 32'h44, 32'h28, 32'h1028, 12'h001);
    step(mk(1'b1, 5'd0, 5'd0, 5'd16, 32'h33, 32'h44, 32'h28, 32'h1028, 12'h001, 1'b0, 16'd4));
    bus.wb_rw = 5'd9;
    set_id(1'b1, 5'd1, 5'd9, 5'd17, 32'h1, 32'h99, 32'h2C, 32'h102C, 12'h001);
    hold_e = mk(1'b1, 5'd1, 5'd9, 5'd17, 32'h1, FWD ? 32'hDEADBEEF : 32'h99, 32'h2C, 32'h102C,
                12'h001, 1'b0, 16'd4);
    step(hold_e);
    bus.wb_reg_write = 1'b0;

    // Reset in the middle of a hold
    bus.ex_busy = 1'b1;
    hold_e.stall = 1'b1; hold_e.cnt = 16'd5;
    step(hold_e);
    reset = 1'b1;
    step(zero(1'b0, 16'd0));
    reset = 1'b0; bus.ex_busy = 1'b0;
    set_id(1'b1, 5'd3, 5'd4, 5'd18, 32'hF1, 32'hF2, 32'h30, 32'h1030, 12'h001);
    hold_e = mk(1'b1, 5'd3, 5'd4, 5'd18, 32'hF1, 32'hF2, 32'h30, 32'h1030, 12'h001, 1'b0, 16'd0);
    step(hold_e);

    // Saturate the stall counter, then clear it with reset
    bus.ex_busy = 1'b1;
    for (int i = 0; i < 65540; i++) begin
      hold_e.stall = 1'b1;
      hold_e.cnt   = (i + 1 > 65535) ? 16'hFFFF : 16'(i + 1);
      step(hold_e);
    end
    reset = 1'b1;
    step(zero(1'b0, 16'd0));

    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
